vga_sprite_engine: RTL

VGA_SPRITE_ENGINE -- requirements
Module: vga_sprite_engine

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/vga_sprite_engine_if.sv | 20 ++
 rtl/sprite_rom.sv | 55 +++++
 rtl/vga_sprite_engine.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared constants for the VGA sprite engine: default 640x480@60
//            timing, colour widths, the transparent bitmap code, the sync
//            pipeline bundle and the 6-bit to 9-bit colour expansion.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int H_SYNC_DEF  = 96;
  localparam int H_BP_DEF    = 48;
  localparam int H_ACT_DEF   = 640;
  localparam int H_TOTAL_DEF = 800;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BP_DEF    = 33;
  localparam int V_ACT_DEF   = 480;
  localparam int V_TOTAL_DEF = 525;

  localparam int CHAN_W = 3;           // bits per output colour channel
  localparam int RGB_W  = 3 * CHAN_W;  // packed {r,g,b}
  localparam int PIX_W  = 6;           // bitmap word RRGGBB

  localparam logic [PIX_W-1:0] PIX_TRANSPARENT = 6'b000000;

  // Timing qualifiers travelling alongside the colour pipeline.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

  // RRGGBB -> {RR,0},{GG,0},{BB,0}
  function automatic logic [RGB_W-1:0] expand_pix(input logic [PIX_W-1:0] p);
    return {p[5:4], 1'b0, p[3:2], 1'b0, p[1:0], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sprite_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_sprite_engine_if
// Purpose  : Read bus between the sprite engine and its bitmap ROM.
//            master : drives addr, receives data one cycle later
//            slave  : samples addr, returns registered data
// Revision : 1.0 - initial release
// ============================================================================
interface vga_sprite_engine_if #(
  parameter int ADDR_W = 12
);
  import vga_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  data;

  modport master (output addr, input  data);
  modport slave  (input  addr, output data);
endinterface
`default_nettype wire

// File: rtl/sprite_rom.sv
`default_nettype none
// ============================================================================
// Module   : sprite_rom
// Purpose  : Sprite bitmap ROM, N_KINDS bitmaps of 2^CELL_LOG2 square pixels,
//            registered output (1-cycle read latency).
//            Address layout {kind[1:0], x[CELL_LOG2-1:0], y[CELL_LOG2-1:0]}.
//            kind 0 : solid red
//            kind 1 : left half green, right half transparent
//            kind 2 : blue with a white main diagonal (x == y)
//            kind 3 : solid white
// Ports    : clk, reset (sync, active-high), bus (slave side of the ROM bus)
// Revision : 1.0 - initial release
// ============================================================================
module sprite_rom
  import vga_pkg::*;
#(
  parameter int CELL_LOG2 = 5,
  parameter int N_KINDS   = 4
) (
  input  logic                clk,
  input  logic                reset,
  vga_sprite_engine_if.slave  bus
);

  logic [1:0]           kind;
  logic [CELL_LOG2-1:0] px;
  logic [CELL_LOG2-1:0] py;
  logic [PIX_W-1:0]     data_d;
  logic [PIX_W-1:0]     data_q;

  // Bitmaps are generated from the address so the ROM needs no preload.
  always_comb begin
    kind   = bus.addr[2*CELL_LOG2 +: 2];
    px     = bus.addr[CELL_LOG2 +: CELL_LOG2];
    py     = bus.addr[0 +: CELL_LOG2];
    data_d = PIX_TRANSPARENT;
    if (int'(kind) < N_KINDS) begin
      case (kind)
        2'd0:    data_d = 6'b110000;
        2'd1:    data_d = px[CELL_LOG2-1] ? PIX_TRANSPARENT : 6'b001100;
        2'd2:    data_d = (px == py) ? 6'b111111 : 6'b000011;
        default: data_d = 6'b111111;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign bus.data = data_q;

endmodule
`default_nettype wire

// File: rtl/vga_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module   : vga_sprite_engine
// Purpose  : VGA timing generator with a cell-aligned sprite overlay.
//            Sprite slots are shadowed at frame start, matched against the
//            active pixel cell (lowest slot wins), looked up in sprite_rom and
//            registered to the pins. Colour and sync share a 3-cycle latency.
// Ports    : clk, reset        - pixel clock, sync active-high reset
//            sprite_col/row/kind/en - packed per-slot sprite descriptors
//            vga_r/g/b         - registered 3-bit colour
//            vga_hs/vga_vs     - registered active-low sync
//            frame_start       - pulse while counters sit at h=0, v=0
//            collision         - per-frame overlap flags against slot 0
// Revision : 1.0 - initial release
// ============================================================================
module vga_sprite_engine
  import vga_pkg::*;
#(
  parameter int         N_SPRITES = 16,
  parameter int         CELL_LOG2 = 5,
  parameter int         N_KINDS   = 4,
  parameter int         H_SYNC    = H_SYNC_DEF,
  parameter int         H_BP      = H_BP_DEF,
  parameter int         H_ACT     = H_ACT_DEF,
  parameter int         H_TOTAL   = H_TOTAL_DEF,
  parameter int         V_SYNC    = V_SYNC_DEF,
  parameter int         V_BP      = V_BP_DEF,
  parameter int         V_ACT     = V_ACT_DEF,
  parameter int         V_TOTAL   = V_TOTAL_DEF,
  parameter logic [8:0] BG_RGB    = 9'b000_100_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SPRITES*5-1:0] sprite_col,
  input  logic [N_SPRITES*4-1:0] sprite_row,
  input  logic [N_SPRITES*2-1:0] sprite_kind,
  input  logic [N_SPRITES-1:0]   sprite_en,
  output logic [CHAN_W-1:0]      vga_r,
  output logic [CHAN_W-1:0]      vga_g,
  output logic [CHAN_W-1:0]      vga_b,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic                   frame_start,
  output logic [N_SPRITES-1:0]   collision
);

  localparam int H_W    = $clog2(H_TOTAL + 1);
  localparam int V_W    = $clog2(V_TOTAL + 1);
  localparam int H_ACT0 = H_SYNC + H_BP;
  localparam int V_ACT0 = V_SYNC + V_BP;
  localparam int ROM_AW = 2 + 2 * CELL_LOG2;

  logic [H_W-1:0]           h_d, h_q;
  logic [V_W-1:0]           v_d, v_q;
  logic [N_SPRITES*5-1:0]   col_d, col_q;
  logic [N_SPRITES*4-1:0]   row_d, row_q;
  logic [N_SPRITES*2-1:0]   kind_d, kind_q;
  logic [N_SPRITES-1:0]     en_d, en_q;
  logic [N_SPRITES-1:0]     collision_d, collision_q;
  sync_t                    sync1_d, sync1_q, sync2_d, sync2_q, sync3_d, sync3_q;
  logic                     hit1_d, hit1_q, hit2_d, hit2_q;
  logic [1:0]               kind1_d, kind1_q;
  logic [CELL_LOG2-1:0]     px1_d, px1_q, py1_d, py1_q;
  logic [RGB_W-1:0]         rgb3_d, rgb3_q;

  logic                     frame_start_w;
  logic                     active_w;
  logic [H_W-1:0]           ax;
  logic [V_W-1:0]           ay;

  vga_sprite_engine_if #(.ADDR_W(ROM_AW)) rom_bus ();

  sprite_rom #(
    .CELL_LOG2 (CELL_LOG2),
    .N_KINDS   (N_KINDS)
  ) u_rom (
    .clk   (clk),
    .reset (reset),
    .bus   (rom_bus.slave)
  );

  // Gated by reset so the pulse first appears on the cycle after release.
  assign frame_start_w = (h_q == '0) && (v_q == '0) && !reset;

  always_comb begin
    // Raster counters
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_W'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == V_W'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
    end

    // Shadow descriptors and collision flags change only at frame start.
    col_d       = col_q;
    row_d       = row_q;
    kind_d      = kind_q;
    en_d        = en_q;
    collision_d = collision_q;
    if (frame_start_w) begin
      col_d       = sprite_col;
      row_d       = sprite_row;
      kind_d      = sprite_kind;
      en_d        = sprite_en;
      collision_d = '0;
      for (int j = 1; j < N_SPRITES; j++) begin
        collision_d[j] = sprite_en[0] && sprite_en[j] &&
                         (sprite_col[5*j +: 5] == sprite_col[4:0]) &&
                         (sprite_row[4*j +: 4] == sprite_row[3:0]);
      end
    end

    // S1: cell match. Gating with active_w also hides cells lying beyond
    // the visible area, since ax/ay never reach them while active.
    active_w = (h_q >= H_W'(H_ACT0)) && (h_q < H_W'(H_ACT0 + H_ACT)) &&
               (v_q >= V_W'(V_ACT0)) && (v_q < V_W'(V_ACT0 + V_ACT));
    ax = h_q - H_W'(H_ACT0);
    ay = v_q - V_W'(V_ACT0);

    hit1_d  = 1'b0;
    kind1_d = '0;
    // Descending scan so the lowest matching slot is the last writer.
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (active_w && en_q[i] &&
          ((ax >> CELL_LOG2) == H_W'(col_q[5*i +: 5])) &&
          ((ay >> CELL_LOG2) == V_W'(row_q[4*i +: 4]))) begin
        hit1_d  = 1'b1;
        kind1_d = kind_q[2*i +: 2];
      end
    end
    px1_d          = ax[CELL_LOG2-1:0];
    py1_d          = ay[CELL_LOG2-1:0];
    sync1_d        = SYNC_IDLE;
    sync1_d.active = active_w;
    sync1_d.hs     = (h_q >= H_W'(H_SYNC));
    sync1_d.vs     = (v_q >= V_W'(V_SYNC));

    // S2: ROM read in flight; qualifiers follow along.
    sync2_d = sync1_q;
    hit2_d  = hit1_q;

    // S3: colour select. A transparent word shows background, never a
    // lower-priority sprite underneath.
    sync3_d = sync2_q;
    rgb3_d  = '0;
    if (sync2_q.active) begin
      if (hit2_q && (rom_bus.data != PIX_TRANSPARENT)) rgb3_d = expand_pix(rom_bus.data);
      else                                              rgb3_d = BG_RGB;
    end
  end

  assign rom_bus.addr = {kind1_q, px1_q, py1_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q         <= '0;
      v_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      kind_q      <= '0;
      en_q        <= '0;
      collision_q <= '0;
      sync1_q     <= SYNC_IDLE;
      hit1_q      <= 1'b0;
      kind1_q     <= '0;
      px1_q       <= '0;
      py1_q       <= '0;
      sync2_q     <= SYNC_IDLE;
      hit2_q      <= 1'b0;
      sync3_q     <= SYNC_IDLE;
      rgb3_q      <= '0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      col_q       <= col_d;
      row_q       <= row_d;
      kind_q      <= kind_d;
      en_q        <= en_d;
      collision_q <= collision_d;
      sync1_q     <= sync1_d;
      hit1_q      <= hit1_d;
      kind1_q     <= kind1_d;
      px1_q       <= px1_d;
      py1_q       <= py1_d;
      sync2_q     <= sync2_d;
      hit2_q      <= hit2_d;
      sync3_q     <= sync3_d;
      rgb3_q      <= rgb3_d;
    end
  end

  assign vga_r       = rgb3_q[8:6];
  assign vga_g       = rgb3_q[5:3];
  assign vga_b       = rgb3_q[2:0];
  assign vga_hs      = sync3_q.hs;
  assign vga_vs      = sync3_q.vs;
  assign frame_start = frame_start_w;
  assign collision   = collision_q;

endmodule
`default_nettype wire
